// File: rtl/parking_sensor_conditioner.sv
// parking_sensor_conditioner
//   Front end for the parking controller. It synchronises and debounces the
//   raw entrance/exit sensor lines and drives the clean levels consumed by
//   parking_system. It also produces one-cycle arrival/departure strobes and
//   keeps a saturating occupancy count with full/empty flags.
//
//   Optional feature macro: SENSOR_STUCK_DETECT_EN
//     defined   - a per-channel clean-high duration counter sets a sticky
//                 stuck_fault once either channel stays high STUCK_CYCLES cycles
//     undefined - no stuck counters are built and stuck_fault is tied to 0
//
// Ports
//   clk              in   rising-edge clock for all state
//   reset_n          in   asynchronous active-low reset
//   raw_entrance     in   unsynchronised entrance sensor
//   raw_exit         in   unsynchronised exit sensor
//   sensor_entrance  out  debounced entrance level
//   sensor_exit      out  debounced exit level
//   entrance_pulse   out  one-cycle strobe on a clean entrance rise
//   exit_pulse       out  one-cycle strobe on a clean exit rise
//   occupancy        out  cars currently inside (saturating, no wrap)
//   lot_full         out  occupancy == CAPACITY
//   lot_empty        out  occupancy == 0
//   stuck_fault      out  sticky stuck-sensor flag
module parking_sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CAPACITY        = 15,
    parameter int unsigned COUNT_W         = 4,
    parameter int unsigned STUCK_CYCLES    = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               raw_entrance,
    input  logic               raw_exit,
    output logic               sensor_entrance,
    output logic               sensor_exit,
    output logic               entrance_pulse,
    output logic               exit_pulse,
    output logic [COUNT_W-1:0] occupancy,
    output logic               lot_full,
    output logic               lot_empty,
    output logic               stuck_fault
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CH_ENT = 0;
    localparam int unsigned CH_EXT = 1;

    // Channel vectors: bit 0 = entrance, bit 1 = exit.
    logic [1:0] raw;
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] clean_q, clean_d;
    logic [1:0] pulse_q, pulse_d;

    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    logic [COUNT_W-1:0] occ_q, occ_d;
    logic               full, empty;

    assign raw = {raw_exit, raw_entrance};

    // Synchroniser, debounce counter and clean level, per channel.
    // The counter only ever holds DEBOUNCE_CYCLES-1 at most: the step that
    // would reach DEBOUNCE_CYCLES toggles the clean level and clears instead.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        clean_d = clean_q;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            db_cnt_d[ch] = '0;
            if (sync2_q[ch] != clean_q[ch]) begin
                if (db_cnt_q[ch] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    clean_d[ch] = ~clean_q[ch];
                end else begin
                    db_cnt_d[ch] = db_cnt_q[ch] + 1'b1;
                end
            end
        end
        // Strobe registered alongside the clean rise so both appear on one edge.
        pulse_d = clean_d & ~clean_q;
    end

    assign full  = (occ_q == COUNT_W'(CAPACITY));
    assign empty = (occ_q == '0);

    // Occupancy acts on the registered strobes, one edge after the pulse.
    always_comb begin
        occ_d = occ_q;
        case ({pulse_q[CH_EXT], pulse_q[CH_ENT]})
            2'b01:   if (!full)  occ_d = occ_q + 1'b1;
            2'b10:   if (!empty) occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            pulse_q <= '0;
            occ_q   <= '0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                db_cnt_q[ch] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            pulse_q <= pulse_d;
            occ_q   <= occ_d;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                db_cnt_q[ch] <= db_cnt_d[ch];
            end
        end
    end

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int unsigned ST_W = $clog2(STUCK_CYCLES + 1);

    logic [ST_W-1:0] stuck_cnt_q [2];
    logic [ST_W-1:0] stuck_cnt_d [2];
    logic            stuck_q, stuck_d;

    // Duration counters saturate at the limit so a long-held level cannot wrap.
    always_comb begin
        stuck_d = stuck_q;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            stuck_cnt_d[ch] = '0;
            if (clean_q[ch]) begin
                if (stuck_cnt_q[ch] == ST_W'(STUCK_CYCLES)) begin
                    stuck_cnt_d[ch] = stuck_cnt_q[ch];
                end else begin
                    stuck_cnt_d[ch] = stuck_cnt_q[ch] + 1'b1;
                end
            end
            if (stuck_cnt_d[ch] == ST_W'(STUCK_CYCLES)) begin
                stuck_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stuck_q <= 1'b0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                stuck_cnt_q[ch] <= '0;
            end
        end else begin
            stuck_q <= stuck_d;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                stuck_cnt_q[ch] <= stuck_cnt_d[ch];
            end
        end
    end

    assign stuck_fault = stuck_q;
`else
    assign stuck_fault = 1'b0;
`endif

    assign sensor_entrance = clean_q[CH_ENT];
    assign sensor_exit     = clean_q[CH_EXT];
    assign entrance_pulse  = pulse_q[CH_ENT];
    assign exit_pulse      = pulse_q[CH_EXT];
    assign occupancy       = occ_q;
    assign lot_full        = full;
    assign lot_empty       = empty;

endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// Self-checking bench for parking_sensor_conditioner. The reference model
// treats each channel as a sliding window of captured raw samples: the clean
// level flips when every sample in the window disagrees with it.
module tb_parking_sensor_conditioner;

    localparam int unsigned DB    = 4;
    localparam int unsigned CAP   = 15;
    localparam int unsigned CW    = 4;
    localparam int unsigned STUCK = 16;
    localparam logic [10:0] RESET_VEC = 11'b0000_0000_010;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          raw_entrance = 1'b0;
    logic          raw_exit = 1'b0;
    logic          sensor_entrance, sensor_exit;
    logic          entrance_pulse, exit_pulse;
    logic [CW-1:0] occupancy;
    logic          lot_full, lot_empty, stuck_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    parking_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CAPACITY(CAP),
        .COUNT_W(CW),
        .STUCK_CYCLES(STUCK)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .raw_entrance(raw_entrance),
        .raw_exit(raw_exit),
        .sensor_entrance(sensor_entrance),
        .sensor_exit(sensor_exit),
        .entrance_pulse(entrance_pulse),
        .exit_pulse(exit_pulse),
        .occupancy(occupancy),
        .lot_full(lot_full),
        .lot_empty(lot_empty),
        .stuck_fault(stuck_fault)
    );

    // ---------------- reference model ----------------
    // hist[ch][0] is the newest captured raw sample, hist[ch][DB] the oldest.
    bit hist [2][DB+1];
    bit m_clean [2];
    bit m_pulse [2];
    int m_occ;
    int m_high [2];
    bit m_stuck;

    function automatic void model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            for (int i = 0; i <= DB; i++) hist[ch][i] = 1'b0;
            m_clean[ch] = 1'b0;
            m_pulse[ch] = 1'b0;
            m_high[ch]  = 0;
        end
        m_occ   = 0;
        m_stuck = 1'b0;
    endfunction

    function automatic void model_edge();
        bit raw [2];
        bit all_diff;
        bit nc;
        if (!reset_n) begin
            model_reset();
            return;
        end
        raw[0] = raw_entrance;
        raw[1] = raw_exit;
        if (m_pulse[0] && !m_pulse[1] && m_occ < CAP) m_occ = m_occ + 1;
        else if (m_pulse[1] && !m_pulse[0] && m_occ > 0) m_occ = m_occ - 1;
`ifdef SENSOR_STUCK_DETECT_EN
        for (int ch = 0; ch < 2; ch++) begin
            if (m_clean[ch]) begin
                m_high[ch] = m_high[ch] + 1;
                if (m_high[ch] >= STUCK) m_stuck = 1'b1;
            end else begin
                m_high[ch] = 0;
            end
        end
`endif
        for (int ch = 0; ch < 2; ch++) begin
            // Sample hist[0] is still in the synchroniser; the window is 1..DB.
            all_diff = 1'b1;
            for (int i = 1; i <= DB; i++) if (hist[ch][i] == m_clean[ch]) all_diff = 1'b0;
            nc = all_diff ? ~m_clean[ch] : m_clean[ch];
            m_pulse[ch] = nc & ~m_clean[ch];
            m_clean[ch] = nc;
            for (int i = DB; i > 0; i--) hist[ch][i] = hist[ch][i-1];
            hist[ch][0] = raw[ch];
        end
    endfunction

    function automatic logic [10:0] obs_vec();
        return {sensor_entrance, sensor_exit, entrance_pulse, exit_pulse,
                occupancy, lot_full, lot_empty, stuck_fault};
    endfunction

    function automatic logic [10:0] exp_vec();
        return {m_clean[0], m_clean[1], m_pulse[0], m_pulse[1], CW'(m_occ),
                (m_occ == CAP), (m_occ == 0), m_stuck};
    endfunction

    // One clock edge; the model advances with it and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        raw_entrance = 1'b0;
        raw_exit     = 1'b0;
        reset_n      = 1'b0;
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Drives one full raw high/low excursion; counts clean-rise strobes.
    task automatic car_pass(input int ch, output int pulses);
        pulses = 0;
        if (ch == 0) raw_entrance = 1'b1; else raw_exit = 1'b1;
        repeat (DB + 3) begin
            tick();
            if (ch == 0 && entrance_pulse) pulses++;
            if (ch == 1 && exit_pulse) pulses++;
        end
        if (ch == 0) raw_entrance = 1'b0; else raw_exit = 1'b0;
        repeat (DB + 3) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        tick();
        total++;
        if (obs_vec() !== RESET_VEC) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b", obs_vec(), RESET_VEC);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (obs_vec() !== RESET_VEC) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", obs_vec(), RESET_VEC);
        end
    endtask

    task automatic test_debounce_latency();
        raw_entrance = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();   // edge k+i-1
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL latency_model i=%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
            if (i == 5) begin
                total++;
                if (sensor_entrance !== 1'b0) begin
                    bad++;
                    $display("FAIL latency_early got=%b want=0", sensor_entrance);
                end
            end
            if (i == 6) begin
                total++;
                if ({sensor_entrance, entrance_pulse} !== 2'b11) begin
                    bad++;
                    $display("FAIL latency_rise got=%b want=11", {sensor_entrance, entrance_pulse});
                end
            end
            if (i == 7) begin
                total++;
                if ({entrance_pulse, occupancy} !== {1'b0, CW'(1)}) begin
                    bad++;
                    $display("FAIL latency_occ got=%b/%0d want=0/1", entrance_pulse, occupancy);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int seen = 0;
        raw_exit = 1'b1;
        repeat (3) begin
            tick();
            if (sensor_exit !== 1'b0 || exit_pulse !== 1'b0) seen++;
        end
        raw_exit = 1'b0;
        repeat (8) begin
            tick();
            if (sensor_exit !== 1'b0 || exit_pulse !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL glitch_leak got=%0d cycles want=0", seen);
        end
        total++;
        if (occupancy !== CW'(1)) begin
            bad++;
            $display("FAIL glitch_occ got=%0d want=1", occupancy);
        end
    endtask

    task automatic test_saturate();
        int p;
        int sum = 0;
        apply_reset();
        for (int n = 0; n < CAP; n++) begin
            car_pass(0, p);
            sum += p;
        end
        total++;
        if ({occupancy, lot_full, lot_empty} !== {CW'(CAP), 2'b10} || sum != CAP) begin
            bad++;
            $display("FAIL fill got=%0d full=%b empty=%b pulses=%0d want=%0d/1/0/%0d",
                     occupancy, lot_full, lot_empty, sum, CAP, CAP);
        end
        car_pass(0, p);
        total++;
        if (p != 1 || occupancy !== CW'(CAP) || lot_full !== 1'b1) begin
            bad++;
            $display("FAIL saturate pulses=%0d occ=%0d full=%b want=1/%0d/1", p, occupancy, lot_full, CAP);
        end
    endtask

    task automatic test_underflow();
        int p;
        apply_reset();
        car_pass(1, p);
        total++;
        if (p != 1 || occupancy !== '0 || lot_empty !== 1'b1) begin
            bad++;
            $display("FAIL underflow pulses=%0d occ=%0d empty=%b want=1/0/1", p, occupancy, lot_empty);
        end
    endtask

    task automatic test_simultaneous();
        int p;
        int both = 0;
        int ent = 0;
        int ext = 0;
        apply_reset();
        repeat (5) car_pass(0, p);
        raw_entrance = 1'b1;
        raw_exit     = 1'b1;
        repeat (DB + 4) begin
            tick();
            if (entrance_pulse) ent++;
            if (exit_pulse) ext++;
            if (entrance_pulse && exit_pulse) both++;
        end
        total++;
        if (both != 1 || ent != 1 || ext != 1) begin
            bad++;
            $display("FAIL simul_pulses both=%0d ent=%0d ext=%0d want=1/1/1", both, ent, ext);
        end
        total++;
        if (occupancy !== CW'(5)) begin
            bad++;
            $display("FAIL simul_occ got=%0d want=5", occupancy);
        end
    endtask

    task automatic test_reset_mid();
        raw_entrance = 1'b0;
        raw_exit     = 1'b0;
        repeat (DB + 3) tick();
        raw_entrance = 1'b1;
        repeat (4) tick();   // edges k..k+3: counter two steps in
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== RESET_VEC) begin
            bad++;
            $display("FAIL midreset_clear got=%b want=%b", obs_vec(), RESET_VEC);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 5) begin
                total++;
                if (sensor_entrance !== 1'b0) begin
                    bad++;
                    $display("FAIL midreset_early got=%b want=0", sensor_entrance);
                end
            end
            if (i == 6) begin
                total++;
                if ({sensor_entrance, entrance_pulse} !== 2'b11) begin
                    bad++;
                    $display("FAIL midreset_rise got=%b want=11", {sensor_entrance, entrance_pulse});
                end
            end
            if (i == 7) begin
                total++;
                if (occupancy !== CW'(1)) begin
                    bad++;
                    $display("FAIL midreset_occ got=%0d want=1", occupancy);
                end
            end
        end
    endtask

    task automatic test_toggle();
        int moved = 0;
        raw_entrance = 1'b1;
        raw_exit     = 1'b1;
        repeat (DB + 4) tick();
        for (int i = 0; i < 40; i++) begin
            raw_entrance = ~raw_entrance;
            raw_exit     = ~raw_exit;
            tick();
            if (sensor_entrance !== 1'b1 || sensor_exit !== 1'b1) moved++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL toggle_model i=%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (moved != 0) begin
            bad++;
            $display("FAIL toggle_hold got=%0d moved cycles want=0", moved);
        end
    endtask

    task automatic test_stuck();
        int waited = 0;
        apply_reset();
        raw_entrance = 1'b1;
        while (sensor_entrance !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        total++;
        if (sensor_entrance !== 1'b1) begin
            bad++;
            $display("FAIL stuck_rise_timeout got=%b want=1", sensor_entrance);
        end
        repeat (STUCK - 1) tick();
        total++;
        if (stuck_fault !== 1'b0) begin
            bad++;
            $display("FAIL stuck_early got=%b want=0", stuck_fault);
        end
        tick();
`ifdef SENSOR_STUCK_DETECT_EN
        total++;
        if (stuck_fault !== 1'b1) begin
            bad++;
            $display("FAIL stuck_set got=%b want=1", stuck_fault);
        end
        raw_entrance = 1'b0;
        repeat (DB + 6) tick();
        total++;
        if (stuck_fault !== 1'b1 || sensor_entrance !== 1'b0) begin
            bad++;
            $display("FAIL stuck_sticky got=%b/%b want=1/0", stuck_fault, sensor_entrance);
        end
`else
        repeat (20) tick();
        raw_entrance = 1'b0;
        repeat (DB + 6) tick();
        total++;
        if (stuck_fault !== 1'b0) begin
            bad++;
            $display("FAIL stuck_disabled got=%b want=0", stuck_fault);
        end
`endif
    endtask

    task automatic test_random();
        int len_e = 0;
        int len_x = 0;
        int errs = 0;
        for (int i = 0; i < 3000; i++) begin
            if (len_e == 0) begin
                raw_entrance = 1'($urandom_range(0, 1));
                len_e = $urandom_range(1, 8);
            end
            if (len_x == 0) begin
                raw_exit = 1'($urandom_range(0, 1));
                len_x = $urandom_range(1, 8);
            end
            len_e--;
            len_x--;
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_model cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_debounce_latency();
        test_glitch();
        test_saturate();
        test_underflow();
        test_simultaneous();
        test_reset_mid();
        test_toggle();
        test_stuck();
        apply_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
